// File: rtl/slave_ram_pkg.sv
// Shared definitions for the slave storage RAM controller.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
package slave_ram_pkg;

  // Clear sequencer states: CLEAR fills the array after reset, IDLE serves users.
  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } clr_state_t;

  // Supported read latencies.
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  // Number of byte lanes in a data word.
  function automatic int lane_cnt(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/slave_ram_core.sv
// Raw byte-enabled storage array: one write port, one registered read port.
// Latency: read data valid one cycle after rd_en; read returns pre-write data.
// Backpressure: none; every enabled access is performed in its cycle.
//
// Ports: clk/rst (rst clears only the read register), wr_en/wr_be/wr_addr/
// wr_data write port, rd_en/rd_addr read request, rd_data registered result
// that holds between reads.
module slave_ram_core
  import slave_ram_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [lane_cnt(DATA_W)-1:0]   wr_be,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          rd_en,
  input  logic [ADDR_W-1:0]             rd_addr,
  output logic [DATA_W-1:0]             rd_data
);

  localparam int NB = lane_cnt(DATA_W);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are deliberately not reset; the controller's clear sequencer fills them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) begin
          mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/slave_ram_ctrl.sv
// Storage RAM controller: post-reset clear, byte writes, range check, RDW policy.
// Latency: read result RD_LAT (1 or 2) cycles after request; clear takes DEPTH cycles.
// Backpressure: none; requests while busy, or out of range, are dropped (the latter flagged).
//
// Ports: clk, rst (sync active-high); we/be/write_addr/data_in write port;
// re/read_addr read request; data_out (held between reads) with rd_valid strobe;
// busy while clearing; addr_err pulse on out-of-range access; clr_done pulse at
// end of clear.
module slave_ram_ctrl
  import slave_ram_pkg::*;
#(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 8,
  parameter int                DEPTH     = 256,
  parameter int                RD_LAT    = 1,
  parameter int                RDW_NEW   = 0,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          we,
  input  logic [lane_cnt(DATA_W)-1:0]   be,
  input  logic [ADDR_W-1:0]             write_addr,
  input  logic [DATA_W-1:0]             data_in,
  input  logic                          re,
  input  logic [ADDR_W-1:0]             read_addr,
  output logic [DATA_W-1:0]             data_out,
  output logic                          rd_valid,
  output logic                          busy,
  output logic                          addr_err,
  output logic                          clr_done
);

  localparam int NB    = lane_cnt(DATA_W);
  // One extra bit so DEPTH == 2**ADDR_W is representable without wrap.
  localparam int PTR_W = ADDR_W + 1;
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_P  = PTR_W'(DEPTH - 1);

  if (DATA_W % 8 != 0 || RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX ||
      DEPTH < 1 || DEPTH > 2**ADDR_W) begin : g_bad_param
    $error("slave_ram_ctrl: illegal parameter combination");
  end

  // ---------------- clear sequencer ----------------
  clr_state_t       state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             clr_done_d;
  logic             clr_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= CLEAR;
      ptr_q    <= '0;
      clr_done <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      clr_done <= clr_done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    clr_done_d = 1'b0;
    clr_we     = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_we = !rst;
        ptr_d  = ptr_q + 1'b1;
        if (ptr_q == LAST_P) begin
          state_d    = IDLE;
          clr_done_d = 1'b1;
        end
      end
      IDLE: begin
        // Terminal until the next reset.
      end
      default: state_d = CLEAR;
    endcase
  end

  assign busy = (state_q == CLEAR);

  // ---------------- request qualification ----------------
  logic idle_ok, wr_in_rng, rd_in_rng;
  logic usr_wr, usr_rd, wr_err, rd_err;

  assign idle_ok   = (state_q == IDLE) && !rst;
  assign wr_in_rng = {1'b0, write_addr} < DEPTH_P;
  assign rd_in_rng = {1'b0, read_addr}  < DEPTH_P;
  assign usr_wr    = idle_ok && we && wr_in_rng;
  assign usr_rd    = idle_ok && re && rd_in_rng;
  assign wr_err    = idle_ok && we && !wr_in_rng;
  assign rd_err    = idle_ok && re && !rd_in_rng;

  // ---------------- storage array ----------------
  logic [DATA_W-1:0] core_q;

  slave_ram_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (clr_we || usr_wr),
    .wr_be   (busy ? {NB{1'b1}} : be),
    .wr_addr (busy ? ptr_q[ADDR_W-1:0] : write_addr),
    .wr_data (busy ? CLEAR_VAL : data_in),
    .rd_en   (usr_rd),
    .rd_addr (read_addr),
    .rd_data (core_q)
  );

  // ---------------- first pipeline stage + RDW bypass ----------------
  logic [DATA_W-1:0] be_mask;
  logic              s1_vld, s1_err, werr_q, byp_hit;
  logic [DATA_W-1:0] byp_mask, byp_dat, rd_word;

  always_comb begin
    be_mask = '0;
    for (int i = 0; i < NB; i++) begin
      be_mask[8*i +: 8] = {8{be[i]}};
    end
  end

  // Bypass state only moves with a valid read so it stays paired with core_q,
  // which is what lets data_out hold across idle and rejected slots.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld   <= 1'b0;
      s1_err   <= 1'b0;
      werr_q   <= 1'b0;
      byp_hit  <= 1'b0;
      byp_mask <= '0;
      byp_dat  <= '0;
    end else begin
      s1_vld <= usr_rd;
      s1_err <= rd_err;
      werr_q <= wr_err;
      if (usr_rd) begin
        byp_hit  <= (RDW_NEW != 0) && usr_wr && (write_addr == read_addr);
        byp_mask <= be_mask;
        byp_dat  <= data_in;
      end
    end
  end

  // The core reads old data; a same-address hit overlays the freshly written lanes.
  assign rd_word = byp_hit ? ((core_q & ~byp_mask) | (byp_dat & byp_mask)) : core_q;

  // ---------------- latency alignment ----------------
  logic rd_err_al;

  if (RD_LAT == 1) begin : g_lat1
    assign data_out  = rd_word;
    assign rd_valid  = s1_vld;
    assign rd_err_al = s1_err;
  end else begin : g_lat2
    logic              s2_vld, s2_err;
    logic [DATA_W-1:0] dout_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        s2_vld <= 1'b0;
        s2_err <= 1'b0;
        dout_q <= '0;
      end else begin
        s2_vld <= s1_vld;
        s2_err <= s1_err;
        if (s1_vld) begin
          dout_q <= rd_word;
        end
      end
    end

    assign data_out  = dout_q;
    assign rd_valid  = s2_vld;
    assign rd_err_al = s2_err;
  end

  // Coinciding write and read errors merge into one pulse.
  assign addr_err = werr_q || rd_err_al;

endmodule

// File: tb/tb_slave_ram_ctrl.sv
module tb_slave_ram_ctrl;

  localparam int N = 3;
  // Instance configurations: {DEPTH, RD_LAT, RDW_NEW}
  localparam int DEP [N] = '{256, 256, 200};
  localparam int LAT [N] = '{1, 2, 1};
  localparam int RDW [N] = '{0, 1, 0};

  logic        clk, rst, we, re;
  logic [1:0]  be;
  logic [7:0]  wa, ra;
  logic [15:0] wd;

  logic [15:0] dout0, dout1, dout2;
  logic        vld0, vld1, vld2, bsy0, bsy1, bsy2;
  logic        aerr0, aerr1, aerr2, cd0, cd1, cd2;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  slave_ram_ctrl #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .RD_LAT(1), .RDW_NEW(0), .CLEAR_VAL(16'h0000)) u_d0 (
    .clk(clk), .rst(rst), .we(we), .be(be), .write_addr(wa), .data_in(wd), .re(re), .read_addr(ra),
    .data_out(dout0), .rd_valid(vld0), .busy(bsy0), .addr_err(aerr0), .clr_done(cd0));

  slave_ram_ctrl #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .RD_LAT(2), .RDW_NEW(1), .CLEAR_VAL(16'h0000)) u_d1 (
    .clk(clk), .rst(rst), .we(we), .be(be), .write_addr(wa), .data_in(wd), .re(re), .read_addr(ra),
    .data_out(dout1), .rd_valid(vld1), .busy(bsy1), .addr_err(aerr1), .clr_done(cd1));

  slave_ram_ctrl #(.DATA_W(16), .ADDR_W(8), .DEPTH(200), .RD_LAT(1), .RDW_NEW(0), .CLEAR_VAL(16'h0000)) u_d2 (
    .clk(clk), .rst(rst), .we(we), .be(be), .write_addr(wa), .data_in(wd), .re(re), .read_addr(ra),
    .data_out(dout2), .rd_valid(vld2), .busy(bsy2), .addr_err(aerr2), .clr_done(cd2));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] mm [N][256];
  int          ptr [N];
  bit          mbusy [N];
  bit          e_cd [N], e_vld [N], e_err [N];
  logic [15:0] e_dout [N];
  // Result slots: index d holds what becomes visible d clock edges from now.
  bit          sv [N][3], se [N][3];
  logic [15:0] sd [N][3];

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw, input logic [1:0] b);
    logic [15:0] r;
    r = old;
    if (b[0]) r[7:0]  = nw[7:0];
    if (b[1]) r[15:8] = nw[15:8];
    return r;
  endfunction

  task automatic model_step();
    logic [15:0] d;
    for (int k = 0; k < N; k++) begin
      if (rst) begin
        mbusy[k] = 1'b1;
        ptr[k]   = 0;
        for (int j = 0; j < 3; j++) begin
          sv[k][j] = 1'b0;
          se[k][j] = 1'b0;
          sd[k][j] = '0;
        end
        e_vld[k]  = 1'b0;
        e_err[k]  = 1'b0;
        e_cd[k]   = 1'b0;
        e_dout[k] = '0;
      end else begin
        e_cd[k] = 1'b0;
        if (mbusy[k]) begin
          mm[k][ptr[k]] = 16'h0000;
          ptr[k]++;
          if (ptr[k] == DEP[k]) begin
            mbusy[k] = 1'b0;
            e_cd[k]  = 1'b1;
          end
        end else begin
          if (re) begin
            if (int'(ra) < DEP[k]) begin
              d = mm[k][ra];
              if (RDW[k] != 0 && we && wa == ra) d = merge(d, wd, be);
              sv[k][LAT[k]] = 1'b1;
              sd[k][LAT[k]] = d;
            end else begin
              se[k][LAT[k]] = 1'b1;
            end
          end
          if (we) begin
            if (int'(wa) < DEP[k]) mm[k][wa] = merge(mm[k][wa], wd, be);
            else se[k][1] = 1'b1;
          end
        end
        e_vld[k] = sv[k][1];
        e_err[k] = se[k][1];
        if (sv[k][1]) e_dout[k] = sd[k][1];
        sv[k][1] = sv[k][2];
        se[k][1] = se[k][2];
        sd[k][1] = sd[k][2];
        sv[k][2] = 1'b0;
        se[k][2] = 1'b0;
        sd[k][2] = '0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  task automatic cmp(input int k, input logic [15:0] d, input logic v, input logic b,
                     input logic e, input logic c);
    chk($sformatf("d%0d_busy", k), b, mbusy[k]);
    chk($sformatf("d%0d_clr_done", k), c, e_cd[k]);
    chk($sformatf("d%0d_rd_valid", k), v, e_vld[k]);
    chk($sformatf("d%0d_addr_err", k), e, e_err[k]);
    chk($sformatf("d%0d_data_out", k), d, e_dout[k]);
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      cmp(0, dout0, vld0, bsy0, aerr0, cd0);
      cmp(1, dout1, vld1, bsy1, aerr1, cd1);
      cmp(2, dout2, vld2, bsy2, aerr2, cd2);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit w, input logic [1:0] b, input logic [7:0] a, input logic [15:0] d,
                     input bit r, input logic [7:0] q);
    we = w; be = b; wa = a; wd = d; re = r; ra = q;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, 2'b00, 8'h00, 16'h0000, 1'b0, 8'h00);
  endtask

  // Counts busy cycles of instance 0 starting with the first rst-low cycle.
  task automatic wait_clear(input bit poke, output int n);
    n = 0;
    while (bsy0 === 1'b1 && n < 2000) begin
      n++;
      if (poke) begin
        we = 1'b1; be = 2'b11; wa = 8'h05; wd = 16'hFFFF; re = 1'b1; ra = 8'h05;
      end
      @(negedge clk);
    end
    we = 1'b0;
    re = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst = 1'b1; we = 1'b0; re = 1'b0; be = 2'b00; wa = 8'h00; ra = 8'h00; wd = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("reset_busy", bsy0, 1);
    chk("reset_data_out", dout0, 16'h0000);
    chk("reset_rd_valid", vld0, 0);
    chk("reset_clr_done", cd0, 0);

    rst = 1'b0;
    wait_clear(1'b0, n);
    chk("clear_cycles", n, 256);
    chk("clr_done_at_fall", cd0, 1);
    idle();
    chk("clr_done_one_cycle", cd0, 0);

    cyc(1'b0, 2'b00, 8'h00, 16'h0000, 1'b1, 8'h00);
    chk("rd00_valid", vld0, 1);
    chk("rd00_data", dout0, 16'h0000);
    cyc(1'b0, 2'b00, 8'h00, 16'h0000, 1'b1, 8'hFF);
    chk("rdFF_valid", vld0, 1);
    chk("rdFF_data", dout0, 16'h0000);
    chk("rdFF_d200_err", aerr2, 1);

    cyc(1'b1, 2'b11, 8'h10, 16'hA5A5, 1'b0, 8'h00);
    cyc(1'b1, 2'b10, 8'h10, 16'h3C00, 1'b0, 8'h00);
    cyc(1'b0, 2'b00, 8'h00, 16'h0000, 1'b1, 8'h10);
    chk("byte_merge_lat1", dout0, 16'h3CA5);
    idle();
    chk("byte_merge_lat2", dout1, 16'h3CA5);

    cyc(1'b1, 2'b11, 8'h01, 16'h0001, 1'b0, 8'h00);
    cyc(1'b1, 2'b11, 8'h02, 16'h0002, 1'b0, 8'h00);
    cyc(1'b1, 2'b11, 8'h03, 16'h0003, 1'b0, 8'h00);
    cyc(1'b1, 2'b11, 8'h20, 16'h1234, 1'b0, 8'h00);

    cyc(1'b0, 2'b00, 8'h00, 16'h0000, 1'b1, 8'h01);
    chk("lat2_c1_valid", vld1, 0);
    cyc(1'b0, 2'b00, 8'h00, 16'h0000, 1'b1, 8'h02);
    chk("lat2_c2_valid", vld1, 1);
    chk("lat2_c2_data", dout1, 16'h0001);
    cyc(1'b0, 2'b00, 8'h00, 16'h0000, 1'b1, 8'h03);
    chk("lat2_c3_valid", vld1, 1);
    chk("lat2_c3_data", dout1, 16'h0002);
    idle();
    chk("lat2_c4_valid", vld1, 1);
    chk("lat2_c4_data", dout1, 16'h0003);
    idle();
    chk("lat2_c5_valid", vld1, 0);
    chk("lat2_c5_hold", dout1, 16'h0003);

    cyc(1'b1, 2'b11, 8'h20, 16'hBEEF, 1'b1, 8'h20);
    chk("rdw_old", dout0, 16'h1234);
    idle();
    chk("rdw_new", dout1, 16'hBEEF);
    cyc(1'b1, 2'b01, 8'h20, 16'h0055, 1'b1, 8'h20);
    chk("rdw_old_partial", dout0, 16'hBEEF);
    idle();
    chk("rdw_new_partial", dout1, 16'hBE55);

    cyc(1'b1, 2'b11, 8'd210, 16'h7777, 1'b0, 8'h00);
    chk("oor_wr_err", aerr2, 1);
    chk("inrange_wr_no_err", aerr0, 0);
    idle();
    chk("oor_wr_err_pulse", aerr2, 0);
    cyc(1'b0, 2'b00, 8'h00, 16'h0000, 1'b1, 8'd250);
    chk("oor_rd_err", aerr2, 1);
    chk("oor_rd_valid", vld2, 0);
    chk("oor_rd_hold", dout2, 16'hBEEF);
    cyc(1'b1, 2'b11, 8'd220, 16'h1111, 1'b1, 8'd230);
    chk("oor_both_err", aerr2, 1);
    idle();
    chk("oor_both_single", aerr2, 0);
    cyc(1'b0, 2'b00, 8'h00, 16'h0000, 1'b1, 8'd210);
    chk("d256_addr210", dout0, 16'h7777);

    rst = 1'b1;
    idle();
    rst = 1'b0;
    for (int i = 0; i < 100; i++) idle();
    chk("midclear_busy", bsy0, 1);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    wait_clear(1'b1, n);
    chk("restart_clear_cycles", n, 256);
    idle();
    cyc(1'b0, 2'b00, 8'h00, 16'h0000, 1'b1, 8'h05);
    chk("busy_poke_ignored", dout0, 16'h0000);
    chk("post_clear_valid", vld0, 1);
    idle();
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/slave_ram_ctrl.md
Name: slave_ram_ctrl

Overview:
- Parametrised successor to the slave's 256x16 storage RAM. Single clock, separate write and read ports.
- Adds per-byte write enables, selectable read latency (1 or 2 cycles) with a read-valid strobe, and selectable read-during-write policy.
- Adds a post-reset clear sequencer that zero-fills (or CLEAR_VAL-fills) the array, and out-of-range address detection for non-power-of-two depths.
- Sits between the SPI slave command decoder and the storage array.

Parameters:
- DATA_W, 16, data width in bits; must be a multiple of 8.
- ADDR_W, 8, address width in bits.
- DEPTH, 256, number of words; 1 <= DEPTH <= 2**ADDR_W.
- RD_LAT, 1, read latency in cycles; legal values 1 or 2.
- RDW_NEW, 0, same-address read-during-write: 0 returns old data, 1 returns newly written data (byte-merged).
- CLEAR_VAL, 0, DATA_W-bit value written to every word by the clear sequencer.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- we  in  1  write request.
- be  in  DATA_W/8  byte enables; bit i covers data_in[8i+7:8i].
- write_addr  in  ADDR_W  write address.
- data_in  in  DATA_W  write data.
- re  in  1  read request.
- read_addr  in  ADDR_W  read address.
- data_out  out  DATA_W  read data; holds its value between reads.
- rd_valid  out  1  one-cycle pulse when data_out carries a new read result.
- busy  out  1  clear sequencer active; user requests are ignored.
- addr_err  out  1  one-cycle pulse flagging an out-of-range access.
- clr_done  out  1  one-cycle pulse when clearing completes.

Behaviour:
- Reset (rst=1 on a posedge):
  - data_out=0, rd_valid=0, addr_err=0, clr_done=0, busy=1, clear pointer=0, read pipeline flushed.
  - Array contents are not reset directly; the clear sequencer overwrites them.
- FSM states: CLEAR, IDLE.
  - Reset enters CLEAR.
  - CLEAR: in each cycle with rst=0, write CLEAR_VAL to mem[ptr] and increment ptr. The first write occurs in the first cycle with rst low.
  - When ptr==DEPTH-1 is written, go to IDLE, drop busy to 0 and pulse clr_done in the following cycle.
  - A full clear takes exactly DEPTH cycles after rst deasserts.
  - rst asserted mid-clear restarts from ptr=0.
  - IDLE is terminal until the next reset.
- While busy=1: we and re are ignored. No writes, no rd_valid, no addr_err.
- Write (IDLE, we=1, write_addr<DEPTH): each byte lane with be[i]=1 is updated at the posedge; lanes with be[i]=0 keep their value. be=0 is a legal no-op.
- Read (IDLE, re=1, read_addr<DEPTH):
  - RD_LAT=1: data_out and rd_valid=1 appear at the next posedge.
  - RD_LAT=2: data_out and rd_valid appear one cycle later.
  - Back-to-back reads are fully pipelined, one result per cycle, in request order.
- Read-during-write, same address, same cycle:
  - RDW_NEW=0: data_out returns pre-write data.
  - RDW_NEW=1: data_out returns the merged word (new bytes where be=1, old bytes elsewhere).
  - Different addresses are independent.
- Out-of-range (addr >= DEPTH):
  - Write: suppressed; addr_err pulses one cycle after the request.
  - Read: data_out keeps its previous value; rd_valid stays 0 for that slot; addr_err pulses at the cycle the result would have appeared (RD_LAT-aligned).
  - Both ports invalid in the same cycle: a single addr_err pulse.
- Arithmetic/width:
  - The clear pointer is ADDR_W+1 bits wide to avoid wrap when DEPTH=2**ADDR_W.
  - Comparisons against DEPTH are unsigned.

Decomposition:
- Package slave_ram_pkg holds: the state enum (CLEAR, IDLE), the function computing byte-lane count from DATA_W, and the RD_LAT legality constants.
- One sub-module, slave_ram_core: the raw byte-enabled array with one write and one registered read port.
- slave_ram_ctrl wraps the core and owns the clear FSM, the RDW bypass mux, the range check, and the latency pipeline.

Test Plan:
- Reset, then idle with DEPTH=256: busy=1 for exactly 256 cycles; clr_done pulses once at the cycle busy falls; reading addr 0x00 and 0xFF returns 0x0000 with rd_valid=1 one cycle later (RD_LAT=1).
- Write 0xA5A5 to addr 0x10 with be=2'b11, then write 0x3C00 to 0x10 with be=2'b10: a read of 0x10 returns 0x3CA5.
- RD_LAT=2: reads of addrs 1, 2, 3 on consecutive cycles (preloaded 0x0001, 0x0002, 0x0003) return those values on cycles +2, +3, +4 with rd_valid continuously high.
- Same-cycle write 0xBEEF and read at addr 0x20 (old value 0x1234): RDW_NEW=0 returns 0x1234; RDW_NEW=1 returns 0xBEEF.
- DEPTH=200: write to addr 210 is suppressed and addr_err pulses; read of addr 250 leaves data_out unchanged, rd_valid=0, addr_err=1.
- rst asserted at clear cycle 100, then released: busy stays high a full 256 more cycles; we/re issued during busy have no effect (addr 0x05 still reads 0x0000).
